lfsr_stream: RTL and testbench
==============================

LFSR_STREAM -- requirements
Module: lfsr_stream

Interface
REQ-001 LFSR_WIDTH, 32, LFSR state width; legal values 8, 16, 32, 64.
REQ-002 OUT_WIDTH, 8, output word width; legal range 1..LFSR_WIDTH.
REQ-003 WARMUP_WORDS, 4, words discarded after reset or seed load; legal range 0..255.
REQ-004 DEFAULT_SEED, all-ones, LFSR_WIDTH-bit nonzero state loaded at reset and substituted for a zero seed.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 seed  in  LFSR_WIDTH  seed value, sampled when seed_valid is high.
REQ-008 seed_limit  in  OUT_WIDTH  inclusive upper bound for output words, sampled with seed.
REQ-009 seed_valid  in  1  single-cycle load strobe for seed and seed_limit.
REQ-010 out_data  out  OUT_WIDTH  random word, valid when out_valid is high.
REQ-011 out_valid  out  1  out_data holds an accepted word.
REQ-012 out_ready  in  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-013 busy  out  1  high in WARM state.

Function
REQ-014 Step: state_next = {fb, state[W-1:1]}, with fb = XOR of state bits at these tap indices: W=8 {0,2,3,4}; W=16 {0,2,3,5}; W=32 {0,10,30,31}; W=64 {0,1,3,4}.
REQ-015 Advance: one "advance" applies OUT_WIDTH steps, fully unrolled, in a single cycle.
REQ-016 Candidate: candidate = state[OUT_WIDTH-1:0] & mask_r, where mask_r is the smallest 2^k-1 that is >= limit_r; limit_r = 0 gives mask_r = 0.
REQ-017 Output data: out_data = candidate, combinational from registered state.
REQ-018 FSM states: WARM and RUN.
- WARM advances once per cycle and decrements warm_cnt.
- WARM moves to RUN when warm_cnt is 0 at a cycle edge; WARMUP_WORDS = 0 enters RUN directly.
REQ-019 RUN, candidate <= limit_r: out_valid = 1; state advances only on a transfer.
REQ-020 RUN, candidate > limit_r: out_valid = 0; state advances automatically every cycle (rejection).
REQ-021 Stability: while out_valid && !out_ready, state and out_data stay unchanged.
REQ-022 Seed load (seed_valid = 1):
- next state = seed, or DEFAULT_SEED if seed = 0;
- limit_r = seed_limit; warm_cnt = WARMUP_WORDS;
- FSM goes to WARM, or to RUN if WARMUP_WORDS = 0.
REQ-023 Seed priority: seed_valid overrides any advance in the same cycle; a coincident transfer still counts as delivered.
REQ-024 Seed timing: seed_valid is legal in any state, including mid-warm-up.
REQ-025 State never becomes zero; this is guaranteed by REQ-004 and REQ-022.

Reset
REQ-026 On rst: state = DEFAULT_SEED, limit_r = all-ones, warm_cnt = WARMUP_WORDS, FSM = WARM (RUN if WARMUP_WORDS = 0).
REQ-027 Output reset values: out_valid = 0 during the reset cycle; busy = 1 if WARMUP_WORDS > 0.
REQ-028 rst has priority over seed_valid.

Structure
REQ-029 Shared package lfsr_pkg holds:
- the FSM state typedef;
- the tap-mask function indexed by width;
- the mask-from-limit function.
REQ-030 Sub-module lfsr_step: combinational, parametrised by width and step count, implements REQ-014/015; used for both advance paths.
REQ-031 Elaboration guard: unsupported LFSR_WIDTH or OUT_WIDTH values raise an elaboration-time error.

Verification
REQ-032 Reset and bit sequence: W=8, OUT=1, WARMUP=0, seed 0x01, limit 1, out_ready=1.
- Required states: 01, 80, 40, 20, 10, 88.
- Required out_data: 1, 0, 0, 0, 0, 0.
REQ-033 Period: W=8, OUT=1, seed 0x01 -> exactly 255 distinct states, and state 0x01 recurs at step 255.
REQ-034 Zero seed: seed 0x00 with DEFAULT_SEED=0xFF -> the first RUN word equals a model seeded with 0xFF after WARMUP advances.
REQ-035 Bounded range and stall:
- W=16, OUT=8, limit 5 -> 2000 words, all within 0..5, and each value appears.
- Hold out_ready=0 for 10 cycles -> out_data and out_valid stay constant.
REQ-036 Warm-up and reseed:
- WARMUP=4 -> busy is high for 4 cycles, then out_valid rises.
- Reseed on a transfer cycle mid-stream -> the word is counted, busy re-asserts, and the stream restarts per the model.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR random-word stream.
package lfsr_pkg;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // Feedback tap positions for each supported width; bit i set means state[i] feeds the XOR.
  function automatic logic [63:0] tap_mask(input int width);
    case (width)
      8:       tap_mask = 64'h0000_0000_0000_001D;  // 0,2,3,4
      16:      tap_mask = 64'h0000_0000_0000_002D;  // 0,2,3,5
      32:      tap_mask = 64'h0000_0000_C000_0401;  // 0,10,30,31
      64:      tap_mask = 64'h0000_0000_0000_001B;  // 0,1,3,4
      default: tap_mask = 64'h0;
    endcase
  endfunction

  // Smallest 2^k-1 that covers limit: smear the top set bit downwards.
  function automatic logic [63:0] mask_from_limit(input logic [63:0] limit);
    logic [63:0] m;
    m = limit;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    m = m | (m >> 32);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR advance: STEPS right-shift steps, fully unrolled.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 8
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  localparam logic [63:0]      TAPS_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] chain [STEPS+1];

  assign chain[0] = state;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    assign chain[i+1] = {^(chain[i] & TAPS), chain[i][WIDTH-1:1]};
  end

  assign next = chain[STEPS];

endmodule

// File: rtl/lfsr_stream.sv
// Bounded random-word source: LFSR with warm-up, rejection sampling and ready/valid output.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH   = 32,
  parameter int                    OUT_WIDTH    = 8,
  parameter int                    WARMUP_WORDS = 4,
  parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic [OUT_WIDTH-1:0]  seed_limit,
  input  logic                  seed_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  if (!(LFSR_WIDTH == 8 || LFSR_WIDTH == 16 || LFSR_WIDTH == 32 || LFSR_WIDTH == 64)) begin : g_bad_lfsr_width
    $error("lfsr_stream: unsupported LFSR_WIDTH %0d", LFSR_WIDTH);
  end
  if (OUT_WIDTH < 1 || OUT_WIDTH > LFSR_WIDTH) begin : g_bad_out_width
    $error("lfsr_stream: unsupported OUT_WIDTH %0d", OUT_WIDTH);
  end
  if (WARMUP_WORDS < 0 || WARMUP_WORDS > 255) begin : g_bad_warmup
    $error("lfsr_stream: unsupported WARMUP_WORDS %0d", WARMUP_WORDS);
  end
  if (DEFAULT_SEED == '0) begin : g_bad_seed
    $error("lfsr_stream: DEFAULT_SEED must be nonzero");
  end

  localparam logic [7:0] WARM_INIT = 8'(WARMUP_WORDS);
  localparam fsm_t       FSM_INIT  = (WARMUP_WORDS == 0) ? RUN : WARM;

  fsm_t                  fsm_q, fsm_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [OUT_WIDTH-1:0]  limit_q, limit_d;
  logic [OUT_WIDTH-1:0]  mask_q, mask_d;
  logic [7:0]            warm_cnt_q, warm_cnt_d;
  logic [63:0]           mask_wide;
  logic [OUT_WIDTH-1:0]  candidate;
  logic                  accept;

  // One instance serves warm-up, rejection and transfer advances alike.
  lfsr_step #(
    .WIDTH (LFSR_WIDTH),
    .STEPS (OUT_WIDTH)
  ) u_adv (
    .state (lfsr_q),
    .next  (lfsr_adv)
  );

  assign mask_wide = mask_from_limit(64'(seed_limit));
  assign mask_d    = mask_wide[OUT_WIDTH-1:0];
  assign candidate = lfsr_q[OUT_WIDTH-1:0] & mask_q;
  assign accept    = (candidate <= limit_q);
  assign out_data  = candidate;
  assign out_valid = !rst && (fsm_q == RUN) && accept;
  assign busy      = rst ? (FSM_INIT == WARM) : (fsm_q == WARM);

  // State register; reset restores the default seed and an unbounded limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= FSM_INIT;
      lfsr_q     <= DEFAULT_SEED;
      limit_q    <= '1;
      mask_q     <= '1;
      warm_cnt_q <= WARM_INIT;
    end else begin
      fsm_q      <= fsm_d;
      lfsr_q     <= lfsr_d;
      limit_q    <= limit_d;
      mask_q     <= (seed_valid) ? mask_d : mask_q;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // Next-state logic: a seed load wins over any advance; otherwise warm-up or run-mode stepping.
  always_comb begin
    fsm_d      = fsm_q;
    lfsr_d     = lfsr_q;
    limit_d    = limit_q;
    warm_cnt_d = warm_cnt_q;
    if (seed_valid) begin
      lfsr_d     = (seed == '0) ? DEFAULT_SEED : seed;
      limit_d    = seed_limit;
      warm_cnt_d = WARM_INIT;
      fsm_d      = FSM_INIT;
    end else begin
      case (fsm_q)
        WARM: begin
          if (warm_cnt_q != 8'd0) begin
            lfsr_d     = lfsr_adv;
            warm_cnt_d = warm_cnt_q - 8'd1;
          end
          if (warm_cnt_q <= 8'd1) begin
            fsm_d = RUN;
          end
        end
        RUN: begin
          if (!accept || out_ready) begin
            lfsr_d = lfsr_adv;
          end
        end
        default: fsm_d = FSM_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: bit sequence, period, zero seed, bounded range, stall, warm-up, reseed.
module tb_lfsr_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: 8-bit LFSR, 1-bit words, no warm-up
  logic       rst_a;
  logic [7:0] a_seed;
  logic [0:0] a_lim;
  logic       a_sv;
  logic [0:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic       a_busy;

  // DUT B: 16-bit LFSR, 8-bit words, 4 warm-up words
  logic        rst_b;
  logic [15:0] b_seed;
  logic [7:0]  b_lim;
  logic        b_sv;
  logic [7:0]  b_data;
  logic        b_valid;
  logic        b_ready;
  logic        b_busy;

  lfsr_stream #(
    .LFSR_WIDTH   (8),
    .OUT_WIDTH    (1),
    .WARMUP_WORDS (0),
    .DEFAULT_SEED (8'hFF)
  ) dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .seed       (a_seed),
    .seed_limit (a_lim),
    .seed_valid (a_sv),
    .out_data   (a_data),
    .out_valid  (a_valid),
    .out_ready  (a_ready),
    .busy       (a_busy)
  );

  lfsr_stream #(
    .LFSR_WIDTH   (16),
    .OUT_WIDTH    (8),
    .WARMUP_WORDS (4),
    .DEFAULT_SEED (16'hFFFF)
  ) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .seed       (b_seed),
    .seed_limit (b_lim),
    .seed_valid (b_sv),
    .out_data   (b_data),
    .out_valid  (b_valid),
    .out_ready  (b_ready),
    .busy       (b_busy)
  );

  logic [7:0] exp_st  [6] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
  logic       exp_bit [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  bit          seen [256];
  int          hit  [8];
  int          distinct;
  int          words;
  int          cycles;
  logic [63:0] m;
  logic [7:0]  cand;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR: n right-shift steps with feedback into the MSB.
  function automatic logic [63:0] madv(input logic [63:0] s, input int w, input int n);
    logic [63:0] r;
    logic        fb;
    r = s;
    for (int i = 0; i < n; i++) begin
      case (w)
        8:       fb = r[0] ^ r[2] ^ r[3] ^ r[4];
        16:      fb = r[0] ^ r[2] ^ r[3] ^ r[5];
        default: fb = r[0] ^ r[1] ^ r[3] ^ r[4];
      endcase
      r = (r >> 1) | (64'(fb) << (w - 1));
    end
    return r;
  endfunction

  // Called at the sample point right after a load (or reset) edge: four busy samples, then the first word.
  task automatic warm_then_word(input string tag, input logic [63:0] m0);
    logic [63:0] w;
    w = madv(m0, 16, 32);
    chk({tag, "_busy"}, 64'(b_busy), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk({tag, "_busy"}, 64'(b_busy), 64'd1);
    end
    tick;
    chk({tag, "_busy_done"}, 64'(b_busy), 64'd0);
    chk({tag, "_valid"}, 64'(b_valid), 64'd1);
    chk({tag, "_word"}, 64'(b_data), 64'(w[7:0]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; a_seed = '0; a_lim = '0; a_sv = 1'b0; a_ready = 1'b1;
    rst_b = 1'b1; b_seed = '0; b_lim = '0; b_sv = 1'b0; b_ready = 1'b1;
    tick;
    tick;

    // Reset cycle values
    chk("a_rst_valid", 64'(a_valid), 64'd0);
    chk("a_rst_busy", 64'(a_busy), 64'd0);
    chk("a_rst_state", 64'(dut_a.lfsr_q), 64'h0FF);
    chk("b_rst_valid", 64'(b_valid), 64'd0);
    chk("b_rst_busy", 64'(b_busy), 64'd1);
    chk("b_rst_state", 64'(dut_b.lfsr_q), 64'hFFFF);

    // Bit sequence from seed 0x01, limit 1
    rst_a = 1'b0; a_sv = 1'b1; a_seed = 8'h01; a_lim = 1'b1;
    tick;
    a_sv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("seq_state", 64'(dut_a.lfsr_q), 64'(exp_st[i]));
      chk("seq_data", 64'(a_data), 64'(exp_bit[i]));
      chk("seq_valid", 64'(a_valid), 64'd1);
      tick;
    end

    // Period from seed 0x01
    a_sv = 1'b1; a_seed = 8'h01;
    tick;
    a_sv = 1'b0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[dut_a.lfsr_q] = 1'b1;
    distinct = 1;
    for (int i = 1; i <= 255; i++) begin
      tick;
      if (i < 255) begin
        if (!seen[dut_a.lfsr_q]) distinct++;
        seen[dut_a.lfsr_q] = 1'b1;
      end else begin
        chk("period_return", 64'(dut_a.lfsr_q), 64'h01);
      end
    end
    chk("period_distinct", 64'(distinct), 64'd255);

    // Warm-up after reset release on B
    rst_b = 1'b0;
    warm_then_word("rst_warm", 64'hFFFF);

    // Zero seed falls back to the default seed
    b_sv = 1'b1; b_seed = 16'h0000; b_lim = 8'hFF;
    tick;
    b_sv = 1'b0;
    warm_then_word("zero_seed", 64'hFFFF);

    // Bounded range: limit 5, 2000 words
    b_sv = 1'b1; b_seed = 16'hACE1; b_lim = 8'd5;
    tick;
    b_sv = 1'b0;
    chk("bnd_busy", 64'(b_busy), 64'd1);
    for (int k = 0; k < 4; k++) tick;
    chk("bnd_run", 64'(b_busy), 64'd0);
    m = madv(64'hACE1, 16, 32);
    for (int v = 0; v < 8; v++) hit[v] = 0;
    words = 0;
    cycles = 0;
    while (words < 2000 && cycles < 6000) begin
      cand = m[7:0] & 8'h07;
      chk("bnd_valid", 64'(b_valid), 64'(cand <= 8'd5));
      if (cand <= 8'd5) begin
        chk("bnd_data", 64'(b_data), 64'(cand));
        chk("bnd_range", 64'(b_data <= 8'd5), 64'd1);
        hit[cand[2:0]]++;
        words++;
      end
      m = madv(m, 16, 8);
      tick;
      cycles++;
    end
    chk("bnd_words", 64'(words), 64'd2000);
    for (int v = 0; v < 6; v++) chk("bnd_hit", 64'(hit[v] > 0), 64'd1);

    // Stall: hold out_ready low, word and valid must hold
    b_ready = 1'b0;
    cycles = 0;
    cand = m[7:0] & 8'h07;
    while (cand > 8'd5 && cycles < 100) begin
      chk("stall_reject", 64'(b_valid), 64'd0);
      m = madv(m, 16, 8);
      tick;
      cycles++;
      cand = m[7:0] & 8'h07;
    end
    for (int k = 0; k <= 10; k++) begin
      chk("stall_valid", 64'(b_valid), 64'd1);
      chk("stall_data", 64'(b_data), 64'(cand));
      if (k < 10) tick;
    end

    // Reseed coinciding with a transfer: the word is offered, then the stream restarts
    b_ready = 1'b1; b_sv = 1'b1; b_seed = 16'h1234; b_lim = 8'hFF;
    chk("reseed_xfer_valid", 64'(b_valid), 64'd1);
    chk("reseed_xfer_data", 64'(b_data), 64'(cand));
    tick;
    b_sv = 1'b0;
    warm_then_word("reseed", 64'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
